// File: rtl/sprite_pkg.sv
// Shared types and helpers for the animated sprite source.
package sprite_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        MANUAL   = 2'b00,
        LOOP     = 2'b01,
        ONESHOT  = 2'b10,
        PINGPONG = 2'b11
    } anim_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } oneshot_state_t;

    // One pulse per frame: the scan has just stepped from x=0 to x=1 on line 0.
    function automatic logic frame_tick_f(input logic [COORD_W-1:0] x_d1,
                                          input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y);
        return (x_d1 == '0) && (x == COORD_W'(1)) && (y == '0);
    endfunction

endpackage

// File: rtl/sprite_frame_ram.sv
// Sprite frame store: one write port, one registered read port (read-old-data on collision).
module sprite_frame_ram
    import sprite_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_w,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr_r,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr_w] <= din;
        dout <= mem[addr_r];
    end

endmodule

// File: rtl/sprite_anim_src.sv
// Animated, mirrorable sprite source with a fixed 2-clock latency.
// Optional 2x texel scaling is enabled by defining SPRITE_SCALE2X_EN.
module sprite_anim_src
    import sprite_pkg::*;
#(
    parameter int            CD        = 12,
    parameter int            H_SIZE    = 16,
    parameter int            V_SIZE    = 16,
    parameter int            N_FRAMES  = 4,
    parameter logic [CD-1:0] KEY_COLOR = '0,
    localparam int           FID_W     = $clog2(N_FRAMES),
    localparam int           ADDR      = FID_W + $clog2(H_SIZE) + $clog2(V_SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [1:0]         mode,
    input  logic [FID_W-1:0]   id_sel,
    input  logic [7:0]         ani_div,
    input  logic               trig,
    input  logic               mirror_h,
    input  logic               mirror_v,
`ifdef SPRITE_SCALE2X_EN
    input  logic               scale2x,
`endif
    input  logic               we,
    input  logic [ADDR-1:0]    addr_w,
    input  logic [CD-1:0]      pixel_in,
    output logic [CD-1:0]      sprite_rgb,
    output logic               hit,
    output logic               busy
);

    localparam int               HW   = $clog2(H_SIZE);
    localparam int               VW   = $clog2(V_SIZE);
    localparam logic [FID_W-1:0] LAST = FID_W'(N_FRAMES - 1);

    logic signed [COORD_W:0] xr, yr, h_lim, v_lim;
    logic [HW-1:0]           col_raw, col;
    logic [VW-1:0]           row_raw, row;
    logic                    in_region, in_region_p1;
    logic [FID_W-1:0]        frame, sid;
    logic [7:0]              div_cnt;
    logic                    dir_down, tick, step, mode_chg;
    logic [COORD_W-1:0]      x_d1;
    anim_mode_t              mode_e, mode_q;
    oneshot_state_t          state;
    logic [CD-1:0]           ram_dout;

    assign mode_e = anim_mode_t'(mode);
    assign xr     = $signed({1'b0, x}) - $signed({1'b0, x0});
    assign yr     = $signed({1'b0, y}) - $signed({1'b0, y0});

`ifdef SPRITE_SCALE2X_EN
    assign h_lim   = scale2x ? (COORD_W+1)'(2 * H_SIZE) : (COORD_W+1)'(H_SIZE);
    assign v_lim   = scale2x ? (COORD_W+1)'(2 * V_SIZE) : (COORD_W+1)'(V_SIZE);
    assign col_raw = scale2x ? xr[HW:1] : xr[HW-1:0];
    assign row_raw = scale2x ? yr[VW:1] : yr[VW-1:0];
`else
    assign h_lim   = (COORD_W+1)'(H_SIZE);
    assign v_lim   = (COORD_W+1)'(V_SIZE);
    assign col_raw = xr[HW-1:0];
    assign row_raw = yr[VW-1:0];
`endif

    assign in_region = !xr[COORD_W] && (xr < h_lim) && !yr[COORD_W] && (yr < v_lim);

    // Sizes are powers of two, so SIZE-1-n is just the bitwise inverse of n.
    assign col = mirror_h ? ~col_raw : col_raw;
    assign row = mirror_v ? ~row_raw : row_raw;

    always_comb begin
        sid = frame;
        if (mode_e == MANUAL || (mode_e == ONESHOT && state == IDLE))
            sid = id_sel;
    end

    assign tick     = frame_tick_f(x_d1, x, y);
    assign step     = tick && (div_cnt >= ani_div);
    assign mode_chg = (mode_e != mode_q);

    // Priority: mode change, then trig, then the divider step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_d1     <= '0;
            mode_q   <= MANUAL;
            frame    <= '0;
            div_cnt  <= '0;
            dir_down <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
        end else begin
            x_d1   <= x;
            mode_q <= mode_e;
            if (mode_chg) begin
                frame    <= '0;
                div_cnt  <= '0;
                dir_down <= 1'b0;
                state    <= IDLE;
                busy     <= 1'b0;
            end else if (mode_e == ONESHOT && trig) begin
                frame   <= '0;
                div_cnt <= '0;
                state   <= RUN;
                busy    <= 1'b1;
            end else begin
                if (tick)
                    div_cnt <= step ? 8'd0 : div_cnt + 8'd1;
                if (step) begin
                    case (mode_e)
                        LOOP:
                            frame <= (frame == LAST) ? '0 : frame + 1'b1;
                        PINGPONG:
                            if (!dir_down) begin
                                if (frame == LAST) begin
                                    dir_down <= 1'b1;
                                    frame    <= frame - 1'b1;
                                end else begin
                                    frame <= frame + 1'b1;
                                end
                            end else begin
                                if (frame == '0) begin
                                    dir_down <= 1'b0;
                                    frame    <= frame + 1'b1;
                                end else begin
                                    frame <= frame - 1'b1;
                                end
                            end
                        ONESHOT:
                            if (state == RUN) begin
                                if (frame == LAST) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                end else begin
                                    frame <= frame + 1'b1;
                                end
                            end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Stage 1: synchronous RAM read, region flag travels alongside.
    sprite_frame_ram #(
        .DATA_WIDTH (CD),
        .ADDR_WIDTH (ADDR)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .addr_w (addr_w),
        .din    (pixel_in),
        .addr_r ({sid, row, col}),
        .dout   (ram_dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            in_region_p1 <= 1'b0;
        else
            in_region_p1 <= in_region;
    end

    // Stage 2: key out-of-region pixels and flag visible ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sprite_rgb <= KEY_COLOR;
            hit        <= 1'b0;
        end else begin
            sprite_rgb <= in_region_p1 ? ram_dout : KEY_COLOR;
            hit        <= in_region_p1 && (ram_dout != KEY_COLOR);
        end
    end

endmodule

// File: tb/tb_sprite_anim_src.sv
// Scoreboard bench for sprite_anim_src: stimulus queues expected pixels, a monitor checks them.
module tb_sprite_anim_src;
    import sprite_pkg::*;

    localparam logic [11:0] KEY = 12'h000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = 11'd500, y = 11'd300, x0 = 11'd100, y0 = 11'd50;
    logic [1:0]  mode = 2'b00;
    logic [1:0]  id_sel = 2'd0;
    logic [7:0]  ani_div = 8'd0;
    logic        trig = 1'b0, mirror_h = 1'b0, mirror_v = 1'b0, we = 1'b0;
    logic [9:0]  addr_w = '0;
    logic [11:0] pixel_in = '0;
    logic [11:0] sprite_rgb;
    logic        hit, busy;

    sprite_anim_src dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .x0         (x0),
        .y0         (y0),
        .mode       (mode),
        .id_sel     (id_sel),
        .ani_div    (ani_div),
        .trig       (trig),
        .mirror_h   (mirror_h),
        .mirror_v   (mirror_v),
`ifdef SPRITE_SCALE2X_EN
        .scale2x    (1'b0),
`endif
        .we         (we),
        .addr_w     (addr_w),
        .pixel_in   (pixel_in),
        .sprite_rgb (sprite_rgb),
        .hit        (hit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        hit;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    logic [11:0] col_c [4] = '{12'hF00, 12'h111, 12'h222, 12'h333};
    int          loop_exp [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int          pp_exp [8] = '{1, 2, 3, 2, 1, 0, 1, 2};

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due != cyc || sprite_rgb !== e.rgb || hit !== e.hit) begin
                errors++;
                $display("FAIL %s: got rgb=%h hit=%b at cycle %0d, want rgb=%h hit=%b at cycle %0d",
                         e.name, sprite_rgb, hit, cyc, e.rgb, e.hit, e.due);
            end
        end
    end

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Apply a scan coordinate for one clock and queue the pixel expected two clocks later.
    task automatic drive(input logic [10:0] dx, input logic [10:0] dy,
                         input logic [11:0] ergb, input logic ehit, input string nm);
        x = dx;
        y = dy;
        q.push_back('{due: cyc + 2, rgb: ergb, hit: ehit, name: nm});
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] f, input logic [3:0] r, input logic [3:0] c,
                      input logic [11:0] d);
        we       = 1'b1;
        addr_w   = {f, r, c};
        pixel_in = d;
        x        = 11'd500;
        y        = 11'd300;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic frame_tick(input logic t);
        drive(11'd0, 11'd0, KEY, 1'b0, "tick_x0");
        trig = t;
        drive(11'd1, 11'd0, KEY, 1'b0, "tick_x1");
        trig = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected pixels never checked, want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {11'd0, busy}, 12'd0);
        chk("rst_rgb", sprite_rgb, KEY);
        chk("rst_hit", {11'd0, hit}, 12'd0);
        reset = 1'b0;

        wr(2'd0, 4'd0,  4'd0,  12'hF00);
        wr(2'd0, 4'd0,  4'd15, 12'h0F0);
        wr(2'd0, 4'd15, 4'd0,  12'h00F);
        wr(2'd0, 4'd0,  4'd1,  12'h000);
        wr(2'd1, 4'd0,  4'd0,  12'h111);
        wr(2'd2, 4'd0,  4'd0,  12'h222);
        wr(2'd3, 4'd0,  4'd0,  12'h333);

        // Region edges and latency
        drive(11'd100, 11'd50, 12'hF00, 1'b1, "origin");
        drive(11'd116, 11'd50, KEY, 1'b0, "x_past_right");
        drive(11'd99,  11'd50, KEY, 1'b0, "x_before_left");
        drive(11'd100, 11'd65, 12'h00F, 1'b1, "y_last_row");
        drive(11'd100, 11'd66, KEY, 1'b0, "y_past_bottom");
        drive(11'd101, 11'd50, KEY, 1'b0, "key_pixel");

        // Mirroring
        mirror_h = 1'b1;
        drive(11'd100, 11'd50, 12'h0F0, 1'b1, "mirror_h");
        mirror_v = 1'b1;
        drive(11'd115, 11'd50, 12'h00F, 1'b1, "mirror_hv");
        mirror_h = 1'b0;
        mirror_v = 1'b0;

        // Loop, ani_div=2
        mode    = 2'b01;
        ani_div = 8'd2;
        drive(11'd500, 11'd300, KEY, 1'b0, "mode_loop");
        for (int k = 0; k < 12; k++) begin
            frame_tick(1'b0);
            drive(11'd100, 11'd50, col_c[loop_exp[k]], 1'b1, "loop_frame");
        end
        repeat (3) frame_tick(1'b0);
        drive(11'd100, 11'd50, 12'h111, 1'b1, "loop_mid");

        // Manual selection, then loop at every frame
        mode   = 2'b00;
        id_sel = 2'd2;
        drive(11'd100, 11'd50, 12'h222, 1'b1, "manual_sel");
        mode    = 2'b01;
        ani_div = 8'd0;
        drive(11'd500, 11'd300, KEY, 1'b0, "mode_loop2");
        frame_tick(1'b0);
        frame_tick(1'b0);
        drive(11'd100, 11'd50, 12'h222, 1'b1, "loop_fast");

        // Ping-pong; the mode change must clear the frame first
        mode = 2'b11;
        drive(11'd500, 11'd300, KEY, 1'b0, "mode_pp");
        drive(11'd100, 11'd50, 12'hF00, 1'b1, "pp_cleared");
        for (int k = 0; k < 8; k++) begin
            frame_tick(1'b0);
            drive(11'd100, 11'd50, col_c[pp_exp[k]], 1'b1, "pp_frame");
        end

        // One-shot
        mode   = 2'b10;
        id_sel = 2'd1;
        drive(11'd500, 11'd300, KEY, 1'b0, "mode_os");
        drive(11'd100, 11'd50, 12'h111, 1'b1, "os_idle_sel");
        chk("os_idle_busy", {11'd0, busy}, 12'd0);
        trig = 1'b1;
        drive(11'd500, 11'd300, KEY, 1'b0, "os_trig");
        trig = 1'b0;
        chk("os_run_busy", {11'd0, busy}, 12'd1);
        drive(11'd100, 11'd50, 12'hF00, 1'b1, "os_frame0");
        for (int k = 1; k < 4; k++) begin
            frame_tick(1'b0);
            drive(11'd100, 11'd50, col_c[k], 1'b1, "os_frame");
            chk("os_busy", {11'd0, busy}, 12'd1);
        end
        frame_tick(1'b0);
        drive(11'd100, 11'd50, 12'h333, 1'b1, "os_done");
        chk("os_done_busy", {11'd0, busy}, 12'd0);
        frame_tick(1'b0);
        drive(11'd100, 11'd50, 12'h333, 1'b1, "os_hold");

        trig = 1'b1;
        drive(11'd500, 11'd300, KEY, 1'b0, "os_retrig");
        trig = 1'b0;
        chk("os_retrig_busy", {11'd0, busy}, 12'd1);
        frame_tick(1'b0);
        frame_tick(1'b0);
        drive(11'd100, 11'd50, 12'h222, 1'b1, "os_frame2");
        frame_tick(1'b1);
        drive(11'd100, 11'd50, 12'hF00, 1'b1, "os_trig_beats_step");
        chk("os_restart_busy", {11'd0, busy}, 12'd1);
        frame_tick(1'b0);
        frame_tick(1'b0);
        drive(11'd100, 11'd50, 12'h222, 1'b1, "os_before_reset");

        // Asynchronous reset during RUN
        drain();
        reset = 1'b1;
        #1;
        chk("async_rst_busy", {11'd0, busy}, 12'd0);
        chk("async_rst_rgb", sprite_rgb, KEY);
        chk("async_rst_hit", {11'd0, hit}, 12'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(11'd100, 11'd50, 12'h111, 1'b1, "post_reset_idle");
        chk("post_reset_busy", {11'd0, busy}, 12'd0);

        // Write colliding with a read of the same address
        mode     = 2'b00;
        id_sel   = 2'd0;
        we       = 1'b1;
        addr_w   = 10'd0;
        pixel_in = 12'hABC;
        drive(11'd100, 11'd50, 12'hF00, 1'b1, "collide_old");
        we = 1'b0;
        drive(11'd100, 11'd50, 12'hABC, 1'b1, "collide_new");

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_anim_src.md
Name: sprite_anim_src

Overview:
- Parametrised next-generation sprite source for the VGA video path, sitting beside the other sprite cores in the frame-buffer/pixel pipeline.
- Stores `N_FRAMES` full-colour sprite frames and compares the scan position against a programmable origin.
- Outputs the sprite pixel, or the chroma key, two clocks after `x`/`y`.
- Adds the following, none of which the earlier fixed 16x16 core has:
  - programmable animation rate;
  - loop, one-shot and ping-pong animation modes;
  - horizontal/vertical mirroring;
  - a hit flag.

Parameters:
- `CD`, 12, colour depth of a pixel.
- `H_SIZE`, 16, sprite width in pixels; power of two, 4..64.
- `V_SIZE`, 16, sprite height in pixels; power of two, 4..64.
- `N_FRAMES`, 4, number of animation frames; 2..16.
- `KEY_COLOR`, 0, chroma-key colour (transparent).
- Derived: `FID_W` = clog2(`N_FRAMES`); `ADDR` = `FID_W` + log2(`H_SIZE`) + log2(`V_SIZE`).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous reset, active-high.
- `x`, `y`  in  11 each  current scan coordinate.
- `x0`, `y0`  in  11 each  sprite origin (top-left).
- `mode`  in  2  animation mode: 00 manual, 01 loop, 10 one-shot, 11 ping-pong.
- `id_sel`  in  `FID_W`  frame shown in manual mode and in one-shot IDLE.
- `ani_div`  in  8  frame ticks per animation step, minus one.
- `trig`  in  1  one-cycle pulse that starts a one-shot sequence.
- `mirror_h`, `mirror_v`  in  1 each  flip horizontally / vertically.
- `we`  in  1  sprite RAM write enable.
- `addr_w`  in  `ADDR`  write address.
- `pixel_in`  in  `CD`  write data.
- `sprite_rgb`  out  `CD`  pixel output.
- `hit`  out  1  in region and pixel != `KEY_COLOR`; aligned with `sprite_rgb`.
- `busy`  out  1  one-shot in progress.

Behaviour:
- **Reset (async, active-high).** `sprite_rgb`=`KEY_COLOR`, `hit`=0, `busy`=0. Frame index, divider count, direction (up) and FSM (IDLE) all cleared. RAM contents are not cleared.
- **Region and address.**
  - Signed 12-bit relative coordinates: xr = x - x0, yr = y - y0.
  - in_region = 0 <= xr < `H_SIZE` and 0 <= yr < `V_SIZE`.
  - col = `mirror_h` ? `H_SIZE`-1-xr : xr; row likewise with `mirror_v`.
  - Read address = {sid, row, col}.
- **Pipeline.**
  - Stage 1: synchronous RAM read, with in_region registered alongside.
  - Stage 2: out = in_region_d ? ram_dout : `KEY_COLOR`, registered into `sprite_rgb`/`hit`.
  - Total latency 2 clocks, fixed.
- **RAM writes.** Independent of reads. A write to the address being read the same cycle returns the old data.
- **Frame tick.** One per frame: x_d1 == 0 && x == 1 && y == 0.
- **Animation divider.**
  - On frame tick: if div_cnt >= `ani_div`, then div_cnt <= 0 and step = 1; else div_cnt increments.
  - `ani_div`=0 means step every frame.
  - Because the compare is >=, lowering `ani_div` mid-count still steps on the next tick.
- **Modes.**
  - Manual (00): sid = `id_sel`; frame counter is not advanced.
  - Loop (01): frame increments on step; wraps from `N_FRAMES`-1 to 0.
  - Ping-pong (11): counts up to `N_FRAMES`-1, then down to 0, reversing at each end. Each end frame is shown for one step only (sequence 0,1,2,3,2,1,0,1,...).
  - One-shot (10) FSM:
    - IDLE: sid = `id_sel`. On `trig`, go to RUN with frame=0 and div_cnt=0.
    - RUN: `busy`=1; frame increments on step. A step while at `N_FRAMES`-1 goes to DONE.
    - DONE: hold frame `N_FRAMES`-1, `busy`=0. On `trig`, restart in RUN.
    - `trig` during RUN restarts at frame 0 with div_cnt cleared.
    - `trig` in any other mode is ignored.
- **Mode change.** Any change of `mode` (detected against a registered copy) clears frame, div_cnt and direction and returns the FSM to IDLE on the next clock.
- **Simultaneity.** A step coinciding with a `trig` or a mode change: the `trig`/mode change wins.

Optional Feature:
- Macro `SPRITE_SCALE2X_EN`.
- Defined:
  - Adds input `scale2x` (1 bit).
  - When `scale2x`=1, the region becomes 2*`H_SIZE` x 2*`V_SIZE`.
  - col/row use xr>>1 / yr>>1 before mirroring, so each texel is doubled.
  - Latency is unchanged.
- Undefined: the port is absent and behaviour is 1x only.

Decomposition:
- Package `sprite_pkg`:
  - `anim_mode_t` enum (MANUAL, LOOP, ONESHOT, PINGPONG);
  - `oneshot_state_t` enum (IDLE, RUN, DONE);
  - localparam `COORD_W`=11;
  - function `frame_tick_f`.
- Sub-module `sprite_frame_ram`: single write port, single synchronous read port, `DATA_WIDTH`/`ADDR_WIDTH` params, inferred BRAM.
- Divider, FSM and address/pipeline logic stay in the top.

Test Plan:
- **Region and latency.** `x0`=100, `y0`=50, pixel at frame0 (row 0, col 0) = 12'hF00. Drive x=100, y=50 → `sprite_rgb`=F00 and `hit`=1 exactly 2 clocks later. x=116 → `KEY_COLOR`, `hit`=0. x=99 → `KEY_COLOR`.
- **Mirroring.** Frame0 (row 0, col 15) = 12'h0F0; `mirror_h`=1, x=x0, y=y0 → 0F0. Then `mirror_v`=1 with (row 15, col 0) = 12'h00F → 00F at x=x0+15, y=y0.
- **Loop timing.** `mode`=01, `ani_div`=2, 12 frame ticks → frames 0,0,0,1,1,1,2,2,2,3,3,3, then wrap to 0 on tick 12.
- **Ping-pong.** `N_FRAMES`=4, `ani_div`=0, 8 frame ticks → 1,2,3,2,1,0,1,2.
- **One-shot.** `mode`=10, `ani_div`=0, pulse `trig` → `busy`=1, frames 0..3 on successive ticks, `busy`=0 and frame 3 held. A second `trig` mid-run (at frame 2) restarts at 0.
- **Reset and mode change.** Assert `reset` during RUN at frame 2 → `busy`=0, `sprite_rgb`=`KEY_COLOR` immediately. Switching `mode` 01→00 mid-loop → sid=`id_sel` on the next frame.
